tdm_cmem_ctrl: RTL

TDM_CMEM_CTRL -- requirements
Module: tdm_cmem_ctrl

---
 rtl/tdm_cmem_ctrl.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/tdm_cmem_ctrl.sv
// Connection-memory controller for a TDM switch: arbitrates two command requesters
// onto the switch MPI port and can bulk-clear the connection memory.
module tdm_cmem_ctrl #(
    parameter int         INIT_WORDS = 264,
    parameter logic [8:0] INIT_DATA  = 9'h000
) (
    input  logic       mpi_clk,
    input  logic       reset,
    input  logic       req0_valid,
    input  logic       req1_valid,
    input  logic [1:0] req0_op,
    input  logic [1:0] req1_op,
    input  logic [7:0] req0_dst,
    input  logic [7:0] req1_dst,
    input  logic [7:0] req0_src,
    input  logic [7:0] req1_src,
    output logic [1:0] req_ready,
    output logic [1:0] rsp_valid,
    output logic [8:0] rsp_data,
    output logic       rsp_err,
    input  logic       init_start,
    output logic       init_done,
    output logic       busy,
    output logic       mpi_cs,
    output logic       mpi_rw,
    output logic [8:0] mpi_addr,
    output logic [8:0] mpi_data_in,
    input  logic [8:0] mpi_data_out
);
    typedef enum logic [2:0] {IDLE, INIT, WR, RD, RDWAIT, RESP} state_t;

    localparam logic [1:0] OP_CONN = 2'b00;
    localparam logic [1:0] OP_DISC = 2'b01;
    localparam logic [1:0] OP_READ = 2'b10;
    localparam logic [8:0] LAST_ADDR = 9'(INIT_WORDS - 1);

    state_t     state;
    logic       last_gnt;
    logic       gnt_id;
    logic [8:0] init_cnt;

    logic       gnt_any;
    logic       gnt_sel;
    logic [1:0] sel_op;
    logic [7:0] sel_dst;
    logic [7:0] sel_src;
    logic       accept;

    // Round-robin: on a tie the requester not granted last time wins.
    always_comb begin
        gnt_any = req0_valid | req1_valid;
        gnt_sel = (req0_valid && req1_valid) ? ~last_gnt : req1_valid;
        sel_op  = gnt_sel ? req1_op  : req0_op;
        sel_dst = gnt_sel ? req1_dst : req0_dst;
        sel_src = gnt_sel ? req1_src : req0_src;
        accept  = (state == IDLE) && !reset && !init_start && gnt_any;
        req_ready = 2'b00;
        if (accept)
            req_ready = gnt_sel ? 2'b10 : 2'b01;
    end

    assign busy = (state != IDLE);

    always_ff @(posedge mpi_clk) begin
        if (reset) begin
            state       <= IDLE;
            last_gnt    <= 1'b1;
            gnt_id      <= 1'b0;
            init_cnt    <= '0;
            mpi_cs      <= 1'b0;
            mpi_rw      <= 1'b1;
            mpi_addr    <= '0;
            mpi_data_in <= '0;
            rsp_valid   <= 2'b00;
            rsp_data    <= '0;
            rsp_err     <= 1'b0;
            init_done   <= 1'b0;
        end else begin
            init_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (init_start) begin
                        state       <= INIT;
                        init_cnt    <= '0;
                        mpi_cs      <= 1'b1;
                        mpi_rw      <= 1'b0;
                        mpi_addr    <= '0;
                        mpi_data_in <= INIT_DATA;
                    end else if (accept) begin
                        gnt_id   <= gnt_sel;
                        last_gnt <= gnt_sel;
                        case (sel_op)
                            OP_CONN, OP_DISC: begin
                                state       <= WR;
                                mpi_cs      <= 1'b1;
                                mpi_rw      <= 1'b0;
                                mpi_addr    <= {1'b0, sel_dst};
                                mpi_data_in <= (sel_op == OP_CONN) ? {1'b1, sel_src} : 9'h000;
                            end
                            OP_READ: begin
                                state    <= RD;
                                mpi_cs   <= 1'b1;
                                mpi_rw   <= 1'b1;
                                mpi_addr <= {1'b0, sel_dst};
                            end
                            default: begin
                                state     <= RESP;
                                rsp_valid <= gnt_sel ? 2'b10 : 2'b01;
                                rsp_data  <= '0;
                                rsp_err   <= 1'b1;
                            end
                        endcase
                    end
                end
                INIT: begin
                    // Counter saturates at the last word; leaving INIT ends the clear.
                    if (init_cnt == LAST_ADDR) begin
                        state     <= IDLE;
                        mpi_cs    <= 1'b0;
                        mpi_rw    <= 1'b1;
                        init_done <= 1'b1;
                    end else begin
                        init_cnt <= init_cnt + 9'd1;
                        mpi_addr <= init_cnt + 9'd1;
                    end
                end
                WR: begin
                    state     <= RESP;
                    mpi_cs    <= 1'b0;
                    mpi_rw    <= 1'b1;
                    rsp_valid <= gnt_id ? 2'b10 : 2'b01;
                    rsp_data  <= '0;
                    rsp_err   <= 1'b0;
                end
                RD: begin
                    state  <= RDWAIT;
                    mpi_cs <= 1'b0;
                    mpi_rw <= 1'b1;
                end
                RDWAIT: begin
                    state     <= RESP;
                    rsp_valid <= gnt_id ? 2'b10 : 2'b01;
                    rsp_data  <= mpi_data_out;
                    rsp_err   <= 1'b0;
                end
                RESP: begin
                    state     <= IDLE;
                    rsp_valid <= 2'b00;
                    rsp_data  <= '0;
                    rsp_err   <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
